// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: retires results into an 8x8 register file,
// latches status flags, and splits MUL products across two registers.
module alu_writeback #(
    parameter  int NREGS = 8,
    parameter  int DW    = 8,
    parameter  int CW    = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opcode,
    input  logic [AW-1:0] in_rd,
    input  logic [DW-1:0] in_res,
    input  logic [DW-1:0] in_msb,
    input  logic [3:0]    in_flag,
    input  logic [AW-1:0] rs_a_addr,
    output logic [DW-1:0] rs_a_data,
    input  logic [AW-1:0] rs_b_addr,
    output logic [DW-1:0] rs_b_data,
    output logic [3:0]    flags_q,
    output logic          wb_done,
    output logic          illegal_op,
    output logic [CW-1:0] retired_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        WR_HI = 1'b1
    } state_t;

    localparam logic [3:0] OP_MUL = 4'b1101;

    state_t        state_q;
    logic [DW-1:0] rf_q [NREGS];
    logic [DW-1:0] hi_data_q;
    logic [AW-1:0] hi_addr_q;

    logic accept;
    logic op_mul;
    logic op_illegal;

    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid & in_ready;
    assign op_mul     = (in_opcode == OP_MUL);
    assign op_illegal = (in_opcode == 4'b1100) | (in_opcode == 4'b1110) |
                        (in_opcode == 4'b1111);

    // No write bypass: a write lands in the array and is seen next cycle.
    assign rs_a_data = rf_q[rs_a_addr];
    assign rs_b_data = rf_q[rs_b_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            flags_q     <= '0;
            wb_done     <= 1'b0;
            illegal_op  <= 1'b0;
            retired_cnt <= '0;
            hi_data_q   <= '0;
            hi_addr_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            wb_done    <= 1'b0;
            illegal_op <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (op_illegal) begin
                            illegal_op  <= 1'b1;
                            wb_done     <= 1'b1;
                            retired_cnt <= retired_cnt + 1'b1;
                        end else begin
                            rf_q[in_rd] <= in_res;
                            flags_q     <= in_flag;
                            if (op_mul) begin
                                // Address wraps naturally in AW bits (7 -> 0).
                                hi_data_q <= in_msb;
                                hi_addr_q <= in_rd + AW'(1);
                                state_q   <= WR_HI;
                            end else begin
                                wb_done     <= 1'b1;
                                retired_cnt <= retired_cnt + 1'b1;
                            end
                        end
                    end
                end
                WR_HI: begin
                    rf_q[hi_addr_q] <= hi_data_q;
                    wb_done         <= 1'b1;
                    retired_cnt     <= retired_cnt + 1'b1;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized bench for alu_writeback against a transaction-level model
// of the register file, flags, counter and pending MUL high-byte writes.
module tb_alu_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [2:0]  in_rd;
    logic [7:0]  in_res;
    logic [7:0]  in_msb;
    logic [3:0]  in_flag;
    logic [2:0]  rs_a_addr;
    logic [7:0]  rs_a_data;
    logic [2:0]  rs_b_addr;
    logic [7:0]  rs_b_data;
    logic [3:0]  flags_q;
    logic        wb_done;
    logic        illegal_op;
    logic [15:0] retired_cnt;

    alu_writeback #(.NREGS(8), .DW(8), .CW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_res     (in_res),
        .in_msb     (in_msb),
        .in_flag    (in_flag),
        .rs_a_addr  (rs_a_addr),
        .rs_a_data  (rs_a_data),
        .rs_b_addr  (rs_b_addr),
        .rs_b_data  (rs_b_data),
        .flags_q    (flags_q),
        .wb_done    (wb_done),
        .illegal_op (illegal_op),
        .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    int          m_reg [8];
    int          m_flags;
    int          m_cnt;
    int          m_done;
    int          m_ill;
    int          pend_addr [$];
    int          pend_data [$];
    bit          known = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("wb_done", 32'(wb_done), 32'(m_done));
        chk("illegal_op", 32'(illegal_op), 32'(m_ill));
        chk("flags", 32'(flags_q), 32'(m_flags));
        chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
        for (int i = 0; i < 8; i++) begin
            rs_a_addr = 3'(i);
            rs_b_addr = 3'(7 - i);
            #1;
            chk("rs_a", 32'(rs_a_data), 32'(m_reg[i]));
            chk("rs_b", 32'(rs_b_data), 32'(m_reg[7 - i]));
        end
    endtask

    // Called at a negedge; applies one cycle of inputs and checks the result.
    task automatic cycle(input logic r, input logic v, input logic [3:0] op,
                         input logic [2:0] rd, input logic [7:0] res,
                         input logic [7:0] msb, input logic [3:0] fl);
        bit ready_exp;
        rst       = r;
        in_valid  = v;
        in_opcode = op;
        in_rd     = rd;
        in_res    = res;
        in_msb    = msb;
        in_flag   = fl;
        #1;
        ready_exp = (pend_addr.size() == 0);
        if (known) chk("in_ready", 32'(in_ready), 32'(ready_exp));
        m_done = 0;
        m_ill  = 0;
        if (r) begin
            foreach (m_reg[i]) m_reg[i] = 0;
            m_flags = 0;
            m_cnt   = 0;
            pend_addr.delete();
            pend_data.delete();
            known = 1;
        end else if (!ready_exp) begin
            m_reg[pend_addr.pop_front()] = pend_data.pop_front();
            m_done = 1;
            m_cnt  = (m_cnt + 1) % 65536;
        end else if (v) begin
            if (op == 4'b1100 || op == 4'b1110 || op == 4'b1111) begin
                m_ill  = 1;
                m_done = 1;
                m_cnt  = (m_cnt + 1) % 65536;
            end else begin
                m_reg[rd] = res;
                m_flags   = fl;
                if (op == 4'b1101) begin
                    pend_addr.push_back((int'(rd) + 1) % 8);
                    pend_data.push_back(int'(msb));
                end else begin
                    m_done = 1;
                    m_cnt  = (m_cnt + 1) % 65536;
                end
            end
        end
        @(negedge clk);
        if (known) check_outputs();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_rd     = '0;
        in_res    = '0;
        in_msb    = '0;
        in_flag   = '0;
        rs_a_addr = '0;
        rs_b_addr = '0;
        @(negedge clk);

        // Reset held two cycles
        cycle(1, 0, 4'h0, 3'd0, 8'h00, 8'h00, 4'h0);
        cycle(1, 0, 4'h0, 3'd0, 8'h00, 8'h00, 4'h0);
        // ADD then MUL, MUL with wrap, illegal op
        cycle(0, 1, 4'b0000, 3'd3, 8'h2A, 8'h00, 4'b0000);
        cycle(0, 1, 4'b1101, 3'd2, 8'h10, 8'hFF, 4'b0100);
        cycle(0, 1, 4'b1101, 3'd2, 8'h10, 8'hFF, 4'b0100);
        cycle(0, 0, 4'b0000, 3'd0, 8'h00, 8'h00, 4'b0000);
        cycle(0, 1, 4'b1101, 3'd7, 8'h01, 8'h80, 4'b1000);
        cycle(0, 1, 4'b1101, 3'd7, 8'h01, 8'h80, 4'b1000);
        cycle(0, 1, 4'b0010, 3'd1, 8'h55, 8'h00, 4'b0011);
        cycle(0, 1, 4'b1110, 3'd1, 8'hAA, 8'h00, 4'b1111);
        // MUL interrupted by reset in WR_HI
        cycle(0, 1, 4'b1101, 3'd4, 8'h33, 8'h44, 4'b0001);
        cycle(1, 1, 4'b1101, 3'd4, 8'h33, 8'h44, 4'b0001);
        cycle(0, 0, 4'b0000, 3'd0, 8'h00, 8'h00, 4'b0000);

        for (int n = 0; n < 2000; n++) begin
            logic       r;
            logic       v;
            logic [3:0] op;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 3) == 0) ? 4'b1101 : 4'($urandom);
            cycle(r, v, op, 3'($urandom), 8'($urandom), 8'($urandom),
                  4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
